reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp.sv | 123 ++++++++++++
 tb/tb_reg_file_mp.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-ported register file: two write ports, two combinational read ports,
// optional hard-wired zero entry and optional write-to-read forwarding.
// A flush request zeroes the array one entry per cycle. User writes that
// arrive during the sweep are discarded and reported.
module reg_file_mp #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 0,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             write1,
   input  logic [WIDTH-1:0] write_data1,
   input  logic [AW-1:0]    write_index1,
   input  logic             write2,
   input  logic [WIDTH-1:0] write_data2,
   input  logic [AW-1:0]    write_index2,
   input  logic [AW-1:0]    read_index_a,
   input  logic [AW-1:0]    read_index_b,
   output logic [WIDTH-1:0] read_value_a,
   output logic [WIDTH-1:0] read_value_b,
   input  logic             flush,
   output logic             busy,
   output logic             flush_done,
   output logic             write_drop
);

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t            r_state;
   logic [AW-1:0]     r_cnt;
   logic              r_busy;
   logic              r_done;
   logic              r_drop;
   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic [WIDTH-1:0]  w_rd_a;
   logic [WIDTH-1:0]  w_rd_b;
   logic              w_fwd_en;

   // Sweep controller: counts through every entry once, then pulses done.
   // r_busy mirrors the SWEEP state so it can gate the write path directly.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_drop  <= 1'b0;
      end else begin
         r_drop <= r_busy && (write1 || write2);
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (flush) begin
                  r_state <= SWEEP;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
               end
            end
            SWEEP: begin
               // counter wraps back to 0 on the final entry
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == AW'(DEPTH - 1)) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Per-entry storage: sweep clear beats user writes; port 1 beats port 2.
   // A flush accepted from IDLE still lets that edge's writes land.
   for (genvar g = 0; g < DEPTH; g++) begin : g_ent
      localparam logic [AW-1:0] IDX = AW'(g);
      always_ff @(posedge clock or negedge clear_n) begin
         if (!clear_n)
            r_mem[g] <= '0;
         else if (ZERO_REG != 0 && g == 0)
            r_mem[g] <= '0;
         else if (r_busy && r_cnt == IDX)
            r_mem[g] <= '0;
         else if (!r_busy && write1 && write_index1 == IDX)
            r_mem[g] <= write_data1;
         else if (!r_busy && write2 && write_index2 == IDX)
            r_mem[g] <= write_data2;
      end
   end

   // forwarding only when writes would actually be accepted
   assign w_fwd_en = (BYPASS != 0) && clear_n && !r_busy;

   // Read port A: array lookup, optional forwarding, zero-entry override.
   always_comb begin
      w_rd_a = r_mem[read_index_a];
      if (w_fwd_en) begin
         if (write1 && write_index1 == read_index_a)      w_rd_a = write_data1;
         else if (write2 && write_index2 == read_index_a) w_rd_a = write_data2;
      end
      if (ZERO_REG != 0 && read_index_a == '0) w_rd_a = '0;
   end

   // Read port B: identical to port A.
   always_comb begin
      w_rd_b = r_mem[read_index_b];
      if (w_fwd_en) begin
         if (write1 && write_index1 == read_index_b)      w_rd_b = write_data1;
         else if (write2 && write_index2 == read_index_b) w_rd_b = write_data2;
      end
      if (ZERO_REG != 0 && read_index_b == '0) w_rd_b = '0;
   end

   assign read_value_a = w_rd_a;
   assign read_value_b = w_rd_b;
   assign busy         = r_busy;
   assign flush_done   = r_done;
   assign write_drop   = r_drop;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a plain-array model tracks expected contents and
// the flush window by edge number; two instances (default, and
// forwarding + zero entry) see identical stimulus.
module tb_reg_file_mp;
   localparam int W  = 32;
   localparam int D  = 32;
   localparam int AW = 5;

   logic          clock = 1'b0;
   logic          clear_n = 1'b0;
   logic          write1 = 1'b0, write2 = 1'b0, flush = 1'b0;
   logic [W-1:0]  wd1 = '0, wd2 = '0;
   logic [AW-1:0] wi1 = '0, wi2 = '0, ra = '0, rb = '0;
   logic [W-1:0]  rva [2];
   logic [W-1:0]  rvb [2];
   logic          bsy [2];
   logic          done [2];
   logic          drop [2];

   int n_chk = 0;
   int n_pass = 0;

   // instance 0: defaults; instance 1: forwarding and hard-wired zero entry
   reg_file_mp u_d0 (
      .clock(clock), .clear_n(clear_n),
      .write1(write1), .write_data1(wd1), .write_index1(wi1),
      .write2(write2), .write_data2(wd2), .write_index2(wi2),
      .read_index_a(ra), .read_index_b(rb),
      .read_value_a(rva[0]), .read_value_b(rvb[0]),
      .flush(flush), .busy(bsy[0]), .flush_done(done[0]), .write_drop(drop[0])
   );

   reg_file_mp #(.BYPASS(1), .ZERO_REG(1)) u_d1 (
      .clock(clock), .clear_n(clear_n),
      .write1(write1), .write_data1(wd1), .write_index1(wi1),
      .write2(write2), .write_data2(wd2), .write_index2(wi2),
      .read_index_a(ra), .read_index_b(rb),
      .read_value_a(rva[1]), .read_value_b(rvb[1]),
      .flush(flush), .busy(bsy[1]), .flush_done(done[1]), .write_drop(drop[1])
   );

   always #5 clock = ~clock;

   // ---------------- model ----------------
   logic [W-1:0] m_mem [2][D];
   int   m_e = 0;       // rising-edge number since reset release
   int   m_k = -1;      // edge at which the current flush was accepted
   logic m_busy = 1'b0, m_done = 1'b0, m_drop = 1'b0;
   logic m_was_busy;

   always @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         for (int c = 0; c < 2; c++)
            for (int i = 0; i < D; i++) m_mem[c][i] = '0;
         m_e = 0; m_k = -1; m_busy = 0; m_done = 0; m_drop = 0;
      end else begin
         m_e++;
         m_was_busy = m_busy;
         if (!m_was_busy) begin
            for (int c = 0; c < 2; c++) begin
               if (write2) m_mem[c][wi2] = wd2;
               if (write1) m_mem[c][wi1] = wd1;
            end
            if (flush) m_k = m_e;
         end
         m_drop = m_was_busy && (write1 || write2);
         // entry i is cleared at edge k+1+i
         if (m_k >= 0 && m_e > m_k && m_e <= m_k + D)
            for (int c = 0; c < 2; c++) m_mem[c][m_e - m_k - 1] = '0;
         m_busy = (m_k >= 0) && (m_e < m_k + D);
         m_done = (m_k >= 0) && (m_e == m_k + D);
         if (m_done) m_k = -1;
      end
   end

   // c==1 is the instance with forwarding and the zero entry
   function automatic logic [W-1:0] exp_rd(int c, logic [AW-1:0] r);
      if (!clear_n) return '0;
      if (c == 1 && r == '0) return '0;
      if (c == 1 && !m_busy) begin
         if (write1 && wi1 == r) return wd1;
         if (write2 && wi2 == r) return wd2;
      end
      return m_mem[c][r];
   endfunction

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
   endtask

   // compare every cycle, away from the active edge
   always @(negedge clock) begin
      for (int c = 0; c < 2; c++) begin
         chk($sformatf("cmp%0d.read_a", c), rva[c], exp_rd(c, ra));
         chk($sformatf("cmp%0d.read_b", c), rvb[c], exp_rd(c, rb));
         chk($sformatf("cmp%0d.busy", c), W'(bsy[c]), W'(m_busy));
         chk($sformatf("cmp%0d.flush_done", c), W'(done[c]), W'(m_done));
         chk($sformatf("cmp%0d.write_drop", c), W'(drop[c]), W'(m_drop));
      end
   end

   // ---------------- stimulus ----------------
   task automatic drv(input logic a1, input logic [AW-1:0] i1, input logic [W-1:0] d1,
                      input logic a2, input logic [AW-1:0] i2, input logic [W-1:0] d2,
                      input logic fl);
      write1 = a1; wi1 = i1; wd1 = d1;
      write2 = a2; wi2 = i2; wd2 = d2;
      flush  = fl;
   endtask

   task automatic idle();
      drv(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [AW-1:0] b);
      ra = a; rb = b;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic fill();
      for (int i = 0; i < D; i += 2) begin
         drv(1'b1, AW'(i), W'(100 + i), 1'b1, AW'(i + 1), W'(101 + i), 1'b0);
         tick();
      end
      idle();
   endtask

   initial begin
      idle();
      rd(0, 1);
      repeat (3) tick();
      // reset state
      chk("rst.busy", W'(bsy[0]), 0);
      chk("rst.done", W'(done[0]), 0);
      chk("rst.drop", W'(drop[0]), 0);
      chk("rst.read_a", rva[0], 0);
      clear_n = 1'b1;
      tick();

      // dual write, different indices
      drv(1'b1, 5'd0, 32'd1081, 1'b1, 5'd1, 32'd2553, 1'b0);
      tick();
      idle(); rd(0, 1); #1;
      chk("dual.a0", rva[0], 32'd1081);
      chk("dual.b0", rvb[0], 32'd2553);
      chk("dual.zero_a1", rva[1], 32'd0);
      chk("dual.b1", rvb[1], 32'd2553);

      // same-index collision: port 1 wins, no drop
      drv(1'b1, 5'd2, 32'd10283, 1'b1, 5'd2, 32'd66, 1'b0);
      tick();
      idle(); rd(2, 2); #1;
      chk("coll.a0", rva[0], 32'd10283);
      chk("coll.drop", W'(drop[0]), 0);

      // forwarding on instance 1, old value on instance 0
      drv(1'b1, 5'd13, 32'd54210, 1'b0, '0, '0, 1'b0);
      rd(13, 13); #1;
      chk("byp.a1", rva[1], 32'd54210);
      chk("byp.a0_old", rva[0], 32'd0);
      tick();
      idle(); #1;
      chk("byp.after_a0", rva[0], 32'd54210);

      // zero entry ignores writes, even forwarded
      drv(1'b1, 5'd0, 32'd7, 1'b0, '0, '0, 1'b0);
      rd(0, 0); #1;
      chk("zr.byp_a1", rva[1], 32'd0);
      tick();
      idle(); #1;
      chk("zr.a1", rva[1], 32'd0);
      chk("zr.a0", rva[0], 32'd7);

      // forwarding priority and port-2 forwarding
      drv(1'b1, 5'd21, 32'd111, 1'b1, 5'd21, 32'd222, 1'b0);
      rd(21, 21); #1;
      chk("prio.a1", rva[1], 32'd111);
      tick();
      drv(1'b0, '0, '0, 1'b1, 5'd20, 32'hABCD, 1'b0);
      rd(20, 0); #1;
      chk("p2byp.a1", rva[1], 32'hABCD);
      tick();
      idle();

      // full sweep with a dropped write and an ignored second flush
      fill();
      drv(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
      tick();                                   // edge k
      idle(); #1;
      chk("sw.busy_k", W'(bsy[0]), 1);
      tick(); tick();                           // k+2
      drv(1'b1, 5'd31, 32'd999, 1'b0, '0, '0, 1'b0);
      rd(31, 31); #1;
      chk("sw.no_byp_busy", rva[1], 32'd131);
      tick();                                   // k+3
      drv(1'b0, '0, '0, 1'b0, '0, '0, 1'b1); #1;
      chk("sw.drop_k3", W'(drop[0]), 1);
      tick();                                   // k+4
      idle(); #1;
      chk("sw.drop_k4", W'(drop[0]), 0);
      tick(); tick();                           // k+6
      rd(5, 6); #1;
      chk("sw.e5_clr", rva[0], 32'd0);
      chk("sw.e6_old", rvb[0], 32'd106);
      repeat (25) tick();                       // k+31
      chk("sw.busy_k31", W'(bsy[0]), 1);
      chk("sw.done_k31", W'(done[0]), 0);
      tick();                                   // k+32
      chk("sw.busy_k32", W'(bsy[0]), 0);
      chk("sw.done_k32", W'(done[0]), 1);
      tick();
      chk("sw.done_k33", W'(done[0]), 0);
      rd(31, 6); #1;
      chk("sw.e31_lost", rva[0], 32'd0);

      // writes alongside an accepted flush land, then get swept
      drv(1'b1, 5'd3, 32'd55, 1'b0, '0, '0, 1'b1);
      tick();                                   // k'
      idle(); rd(3, 3); #1;
      chk("wf.k", rva[0], 32'd55);
      repeat (3) tick();
      chk("wf.k3", rva[0], 32'd55);
      tick();
      chk("wf.k4", rva[0], 32'd0);
      repeat (28) tick();                       // k'+32
      chk("wf.done", W'(done[0]), 1);

      // reset in the middle of a sweep
      fill();
      drv(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
      tick();                                   // k
      idle();
      rd(20, 21);
      repeat (10) tick();                       // k+10
      clear_n = 1'b0;
      drv(1'b1, 5'd20, 32'd5, 1'b0, '0, '0, 1'b1);
      #1;
      chk("ar.busy", W'(bsy[0]), 0);
      chk("ar.done", W'(done[0]), 0);
      chk("ar.drop", W'(drop[0]), 0);
      chk("ar.a0", rva[0], 32'd0);
      chk("ar.a1_byp", rva[1], 32'd0);
      tick(); tick();
      idle();
      clear_n = 1'b1;
      for (int i = 0; i < D; i++) begin
         rd(AW'(i), AW'(D - 1 - i));
         tick();
      end
      chk("ar.busy_end", W'(bsy[0]), 0);
      chk("ar.done_end", W'(done[0]), 0);
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // safety net so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1);
   end

endmodule
